// File: rtl/timeout_retry_ctrl.sv
// ---------------------------------------------------------------------------
// timeout_retry_ctrl
//
// Supervises one operation at a time against an external timeout counter.
// An operation starts from IDLE, is watched in ARMED, and on each timeout is
// either retried (RETRY handshake, then a fixed BACKOFF wait before re-arming)
// or, once the retry budget is spent, parked in FAIL until software clears it.
//
// Parameters
//   MAX_RETRY     retries allowed before a timeout sends the FSM to FAIL
//   BACKOFF_CYC   cycles spent in BACKOFF after a retry handshake (0 acts as 1)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          begin monitoring an operation (honoured only in IDLE)
//   timeout_pulse  single-cycle timeout from the upstream counter
//   ack            operation completed successfully
//   retry_ready    consumer accepts the retry request
//   fail_clr       leave FAIL and return to IDLE
//   cnt_clr        single-cycle clear request to the upstream timeout counter
//   retry_req      retry request (valid half of the handshake)
//   retry_cnt      retries issued for the current operation
//   ok_pulse       single-cycle success indication
//   fail           retry budget exhausted (level)
//   busy           high in ARMED, RETRY and BACKOFF
//   state          encoded FSM state: IDLE=0 ARMED=1 RETRY=2 BACKOFF=3 FAIL=4
// ---------------------------------------------------------------------------
module timeout_retry_ctrl #(
    parameter logic [3:0] MAX_RETRY   = 4'd3,
    parameter logic [7:0] BACKOFF_CYC = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       timeout_pulse,
    input  logic       ack,
    input  logic       retry_ready,
    input  logic       fail_clr,
    output logic       cnt_clr,
    output logic       retry_req,
    output logic [3:0] retry_cnt,
    output logic       ok_pulse,
    output logic       fail,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RETRY   = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    // The counter runs down to zero inclusive, so loading N-1 yields N cycles.
    // A zero setting is clamped to a single BACKOFF cycle.
    localparam logic [7:0] BACKOFF_LOAD =
        (BACKOFF_CYC == 8'd0) ? 8'd0 : (BACKOFF_CYC - 8'd1);

    state_t     state_r;
    logic [7:0] backoff_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            retry_cnt   <= 4'd0;
            backoff_cnt <= 8'd0;
            cnt_clr     <= 1'b0;
            retry_req   <= 1'b0;
            ok_pulse    <= 1'b0;
            fail        <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a transition raises them.
            cnt_clr  <= 1'b0;
            ok_pulse <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_ARMED;
                        retry_cnt <= 4'd0;
                        cnt_clr   <= 1'b1;
                    end
                end

                ST_ARMED: begin
                    // Completion wins over a timeout arriving in the same cycle.
                    if (ack) begin
                        state_r  <= ST_IDLE;
                        ok_pulse <= 1'b1;
                    end else if (timeout_pulse) begin
                        if (retry_cnt < MAX_RETRY) begin
                            state_r   <= ST_RETRY;
                            retry_req <= 1'b1;
                        end else begin
                            state_r <= ST_FAIL;
                            fail    <= 1'b1;
                        end
                    end
                end

                ST_RETRY: begin
                    // retry_req stays high until the consumer takes it.
                    if (retry_ready) begin
                        state_r     <= ST_BACKOFF;
                        retry_req   <= 1'b0;
                        backoff_cnt <= BACKOFF_LOAD;
                        if (retry_cnt < MAX_RETRY) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end
                end

                ST_BACKOFF: begin
                    if (backoff_cnt == 8'd0) begin
                        state_r <= ST_ARMED;
                        cnt_clr <= 1'b1;
                    end else begin
                        backoff_cnt <= backoff_cnt - 8'd1;
                    end
                end

                ST_FAIL: begin
                    if (fail_clr) begin
                        state_r   <= ST_IDLE;
                        fail      <= 1'b0;
                        retry_cnt <= 4'd0;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean IDLE.
                    state_r   <= ST_IDLE;
                    retry_req <= 1'b0;
                    fail      <= 1'b0;
                    retry_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign state = state_r;
    assign busy  = (state_r != ST_IDLE) && (state_r != ST_FAIL);

endmodule

// File: tb/tb_timeout_retry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timeout_retry_ctrl
//
// Directed bench for timeout_retry_ctrl. Three instances share the stimulus:
//   u_dut  default parameters (MAX_RETRY=3, BACKOFF_CYC=8)
//   u_b0   MAX_RETRY=1, BACKOFF_CYC=0 (single-cycle backoff, small budget)
//   u_m0   MAX_RETRY=0, BACKOFF_CYC=8 (first timeout goes straight to FAIL)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_timeout_retry_ctrl;

    logic clk = 1'b0;
    logic rst, start, timeout_pulse, ack, retry_ready, fail_clr;

    logic       cnt_clr_a, retry_req_a, ok_pulse_a, fail_a, busy_a;
    logic [3:0] retry_cnt_a;
    logic [2:0] state_a;

    logic       cnt_clr_b, retry_req_b, ok_pulse_b, fail_b, busy_b;
    logic [3:0] retry_cnt_b;
    logic [2:0] state_b;

    logic       cnt_clr_m, retry_req_m, ok_pulse_m, fail_m, busy_m;
    logic [3:0] retry_cnt_m;
    logic [2:0] state_m;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    timeout_retry_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .timeout_pulse(timeout_pulse),
        .ack(ack), .retry_ready(retry_ready), .fail_clr(fail_clr),
        .cnt_clr(cnt_clr_a), .retry_req(retry_req_a), .retry_cnt(retry_cnt_a),
        .ok_pulse(ok_pulse_a), .fail(fail_a), .busy(busy_a), .state(state_a)
    );

    timeout_retry_ctrl #(.MAX_RETRY(4'd1), .BACKOFF_CYC(8'd0)) u_b0 (
        .clk(clk), .rst(rst), .start(start), .timeout_pulse(timeout_pulse),
        .ack(ack), .retry_ready(retry_ready), .fail_clr(fail_clr),
        .cnt_clr(cnt_clr_b), .retry_req(retry_req_b), .retry_cnt(retry_cnt_b),
        .ok_pulse(ok_pulse_b), .fail(fail_b), .busy(busy_b), .state(state_b)
    );

    timeout_retry_ctrl #(.MAX_RETRY(4'd0), .BACKOFF_CYC(8'd8)) u_m0 (
        .clk(clk), .rst(rst), .start(start), .timeout_pulse(timeout_pulse),
        .ack(ack), .retry_ready(retry_ready), .fail_clr(fail_clr),
        .cnt_clr(cnt_clr_m), .retry_req(retry_req_m), .retry_cnt(retry_cnt_m),
        .ok_pulse(ok_pulse_m), .fail(fail_m), .busy(busy_m), .state(state_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full output snapshot of the default instance.
    task automatic chk_a(input string tag, input logic [2:0] st, input logic [3:0] rc,
                         input logic cc, input logic rr, input logic ok,
                         input logic fl, input logic bz);
        chk({tag, ".state"},     32'(state_a),     32'(st));
        chk({tag, ".retry_cnt"}, 32'(retry_cnt_a), 32'(rc));
        chk({tag, ".cnt_clr"},   32'(cnt_clr_a),   32'(cc));
        chk({tag, ".retry_req"}, 32'(retry_req_a), 32'(rr));
        chk({tag, ".ok_pulse"},  32'(ok_pulse_a),  32'(ok));
        chk({tag, ".fail"},      32'(fail_a),      32'(fl));
        chk({tag, ".busy"},      32'(busy_a),      32'(bz));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; timeout_pulse = 1'b0; ack = 1'b0;
        retry_ready = 1'b0; fail_clr = 1'b0;
        tick(); tick();
        chk_a("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_a("post_reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start then ack five cycles later.
        start = 1'b1; tick(); start = 1'b0;
        chk_a("start", 3'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_a("armed_wait", 3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("armed_hold.state", 32'(state_a), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_a("ack", 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ok_single.ok_pulse", 32'(ok_pulse_a), 32'd0);

        // Timeout while idle is ignored; start while armed is ignored.
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        chk_a("idle_timeout", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick();
        chk("start2.state", 32'(state_a), 32'd1);
        tick(); tick();
        chk_a("start_held", 3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;

        // Timeout, retry_ready low for three RETRY cycles, then backoff.
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        chk_a("retry_c1", 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        ack = 1'b1; timeout_pulse = 1'b1; tick(); ack = 1'b0; timeout_pulse = 1'b0;
        chk_a("retry_c2", 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_a("retry_c3", 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        retry_ready = 1'b1; tick(); retry_ready = 1'b0;
        chk_a("handshake", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            if (i == 4) begin ack = 1'b1; timeout_pulse = 1'b1; end
            tick();
            ack = 1'b0; timeout_pulse = 1'b0;
            chk($sformatf("backoff_c%0d.state", i), 32'(state_a), 32'd3);
        end
        tick();
        chk_a("rearm", 3'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rearm_next.cnt_clr", 32'(cnt_clr_a), 32'd0);

        // ack and timeout together in ARMED: ack wins.
        ack = 1'b1; timeout_pulse = 1'b1; tick(); ack = 1'b0; timeout_pulse = 1'b0;
        chk("ack_vs_to.state", 32'(state_a), 32'd0);
        chk("ack_vs_to.ok_pulse", 32'(ok_pulse_a), 32'd1);
        chk("ack_vs_to.retry_req", 32'(retry_req_a), 32'd0);
        tick();
        chk("ack_vs_to_next.retry_req", 32'(retry_req_a), 32'd0);

        // Retry budget exhaustion with retry_ready always high.
        retry_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("budget_start.retry_cnt", 32'(retry_cnt_a), 32'd0);
        for (int r = 1; r <= 3; r++) begin
            timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
            chk($sformatf("budget_to%0d.state", r), 32'(state_a), 32'd2);
            tick();
            chk($sformatf("budget_hs%0d.retry_cnt", r), 32'(retry_cnt_a), 32'(r));
            for (int k = 0; k < 8; k++) tick();
            chk($sformatf("budget_rearm%0d.state", r), 32'(state_a), 32'd1);
        end
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        chk_a("exhausted", 3'd4, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; ack = 1'b1; tick(); start = 1'b0; ack = 1'b0;
        chk_a("fail_hold", 3'd4, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        chk_a("fail_clr", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        retry_ready = 1'b0;

        // Asynchronous reset in the middle of BACKOFF.
        start = 1'b1; tick(); start = 1'b0;
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        retry_ready = 1'b1; tick(); retry_ready = 1'b0;
        tick(); tick();
        chk("pre_rst.state", 32'(state_a), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk_a("async_rst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        chk_a("after_rst1", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk_a("after_rst2", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Parameter corners: single-cycle backoff and zero retry budget.
        start = 1'b1; tick(); start = 1'b0;
        chk("b0_start.state", 32'(state_b), 32'd1);
        chk("m0_start.state", 32'(state_m), 32'd1);
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        chk("b0_to.state", 32'(state_b), 32'd2);
        chk("m0_to.state", 32'(state_m), 32'd4);
        chk("m0_to.fail", 32'(fail_m), 32'd1);
        chk("m0_to.retry_cnt", 32'(retry_cnt_m), 32'd0);
        chk("m0_to.retry_req", 32'(retry_req_m), 32'd0);
        retry_ready = 1'b1; tick(); retry_ready = 1'b0;
        chk("b0_hs.state", 32'(state_b), 32'd3);
        chk("b0_hs.retry_cnt", 32'(retry_cnt_b), 32'd1);
        tick();
        chk("b0_rearm.state", 32'(state_b), 32'd1);
        chk("b0_rearm.cnt_clr", 32'(cnt_clr_b), 32'd1);
        timeout_pulse = 1'b1; tick(); timeout_pulse = 1'b0;
        chk("b0_sat.state", 32'(state_b), 32'd4);
        chk("b0_sat.retry_cnt", 32'(retry_cnt_b), 32'd1);
        chk("b0_sat.busy", 32'(busy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
